// File: rtl/instr_fetch_pkg.sv
// Purpose: shared codes and types for the instruction-fetch stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Contents: decoder Branch codes, fetch FSM states, reset PC default,
// queue entry layout and a sequential-PC helper.
package instr_fetch_pkg;

   // Decoder Branch field encoding; 2'b11 is reserved and behaves as none.
   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEQ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } q_entry_t;

   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/instr_fetch_npc_calc.sv
// Purpose: decide whether resolved control flow redirects fetch, and where to.
// Latency: combinational.
// Backpressure: none; evaluated every cycle from the br_* inputs.
//
// Ports: br_valid/br_jump/br_type/br_zero qualify the redirect; br_pc,
// br_imm16, br_jidx form the target; redirect and target are the results.
module instr_fetch_npc_calc
   import instr_fetch_pkg::*;
(
   input  logic        br_valid,
   input  logic        br_jump,
   input  logic [1:0]  br_type,
   input  logic        br_zero,
   input  logic [31:0] br_pc,
   input  logic [15:0] br_imm16,
   input  logic [25:0] br_jidx,
   output logic        redirect,
   output logic [31:0] target
);

   logic        taken;
   logic [31:0] pc_plus4;

   assign pc_plus4 = seq_pc(br_pc);

   always_comb begin
      taken = 1'b0;
      case (br_type)
         BR_BEQ:  taken = br_zero;
         BR_BNE:  taken = !br_zero;
         BR_NONE: taken = 1'b0;
         default: taken = 1'b0;
      endcase
   end

   assign redirect = br_valid && (br_jump || taken);

   // Jump wins over any branch code presented alongside it.
   assign target = br_jump ? {pc_plus4[31:28], br_jidx, 2'b00}
                           : pc_plus4 + {{14{br_imm16[15]}}, br_imm16, 2'b00};

endmodule

// File: rtl/instr_fetch.sv
// Purpose: fetch stage; owns the PC, fetches over req/ack, queues words for the decoder.
// Latency: fetched word visible at if_valid one cycle after imem_ack.
// Backpressure: id_stall holds the head; no new request is issued while the queue is full.
//
// Ports: clk/rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata
// memory port; if_valid/if_pc/if_instr/if_opcode/if_funct queue head to the
// decoder; id_stall from decode; br_* resolved control flow.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic [5:0]  if_opcode,
   output logic [5:0]  if_funct,
   input  logic        id_stall,
   input  logic        br_valid,
   input  logic        br_jump,
   input  logic [1:0]  br_type,
   input  logic        br_zero,
   input  logic [31:0] br_pc,
   input  logic [15:0] br_imm16,
   input  logic [25:0] br_jidx
);

   localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   fetch_state_t  state;
   logic [31:0]   pc;
   logic [31:0]   req_addr;
   q_entry_t      q [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          redirect;
   logic [31:0]   target;
   logic          push;
   logic          pop;
   q_entry_t      head;

   instr_fetch_npc_calc u_npc (
      .br_valid (br_valid),
      .br_jump  (br_jump),
      .br_type  (br_type),
      .br_zero  (br_zero),
      .br_pc    (br_pc),
      .br_imm16 (br_imm16),
      .br_jidx  (br_jidx),
      .redirect (redirect),
      .target   (target)
   );

   // Only an ack to a live request (REQ) is kept; acks in IDLE or DROP are
   // stale and dropped. A redirect in the same cycle squashes the word.
   assign push = (state == ST_REQ) && imem_ack && !redirect;
   assign pop  = if_valid && !id_stall;

   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + CNT_ONE;
      end else if (pop && !push) begin
         count_nxt = count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         pc       <= RESET_PC;
         req_addr <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q[i] <= '0;
         end
      end else begin
         // Queue: a redirect empties it and overrides any push/pop this cycle.
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               q[wr_ptr] <= '{pc: req_addr, instr: imem_rdata};
               wr_ptr    <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
         end

         // Fetch FSM. In REQ, pc always equals req_addr; in DROP, pc already
         // holds the redirect target while the old request drains.
         case (state)
            ST_IDLE: begin
               if (redirect) begin
                  // Queue is emptied this cycle, so a slot is guaranteed.
                  pc       <= target;
                  req_addr <= target;
                  state    <= ST_REQ;
               end else if (count < FULL) begin
                  req_addr <= pc;
                  state    <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (imem_ack) begin
                  if (redirect) begin
                     pc       <= target;
                     req_addr <= target;
                  end else begin
                     pc <= seq_pc(pc);
                     if (count_nxt < FULL) begin
                        req_addr <= seq_pc(pc);
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end else if (redirect) begin
                  // Request stays on the bus until its ack, which is discarded.
                  pc    <= target;
                  state <= ST_DROP;
               end
            end
            ST_DROP: begin
               if (redirect) begin
                  pc <= target;
               end
               // The queue was flushed on entry and nothing is pushed while
               // draining, so there is always room to reissue right away.
               if (imem_ack) begin
                  req_addr <= redirect ? target : pc;
                  state    <= ST_REQ;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign imem_req  = (state != ST_IDLE);
   assign imem_addr = req_addr;

   assign head      = q[rd_ptr];
   assign if_valid  = (count != '0);
   assign if_pc     = if_valid ? head.pc : '0;
   assign if_instr  = if_valid ? head.instr : '0;
   assign if_opcode = if_instr[31:26];
   assign if_funct  = if_instr[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [5:0]  if_opcode;
   logic [5:0]  if_funct;
   logic        id_stall;
   logic        br_valid;
   logic        br_jump;
   logic [1:0]  br_type;
   logic        br_zero;
   logic [31:0] br_pc;
   logic [15:0] br_imm16;
   logic [25:0] br_jidx;

   int checks   = 0;
   int failures = 0;
   int pops     = 0;

   // Reference model: the ordered PCs the decoder must see next.
   logic [31:0] exp_q[$];
   logic [31:0] model_next;

   // Memory responder controls.
   int lat_max   = 0;
   bit lat_fixed = 1'b0;
   bit stale_ack = 1'b0;
   int wait_cnt  = -1;

   // Monitor history (values that applied at the previous clock edge).
   logic        p_rst   = 1'b0;
   logic        p_redir = 1'b0;
   logic        p_req   = 1'b0;
   logic        p_ack   = 1'b0;
   logic [31:0] p_addr  = 32'd0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .if_opcode  (if_opcode),
      .if_funct   (if_funct),
      .id_stall   (id_stall),
      .br_valid   (br_valid),
      .br_jump    (br_jump),
      .br_type    (br_type),
      .br_zero    (br_zero),
      .br_pc      (br_pc),
      .br_imm16   (br_imm16),
      .br_jidx    (br_jidx)
   );

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic bit m_redirect(input logic v, input logic j, input logic [1:0] t, input logic z);
      return v && (j || (t == 2'd1 && z) || (t == 2'd2 && !z));
   endfunction

   function automatic logic [31:0] m_target(input logic j, input logic [31:0] pc,
                                             input logic [15:0] imm, input logic [25:0] jidx);
      logic [31:0] seq;
      int          off;
      seq = pc + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ({6'd0, jidx} << 2);
      off = int'($signed(imm));
      return seq + $unsigned(off * 4);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, req);
      end
   endtask

   task automatic refill();
      while (exp_q.size() < 8) begin
         exp_q.push_back(model_next);
         model_next = model_next + 32'd4;
      end
   endtask

   task automatic model_restart(input logic [31:0] start);
      exp_q.delete();
      model_next = start;
      refill();
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic post();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic stall, input logic v, input logic j, input logic [1:0] t,
                        input logic z, input logic [31:0] pc, input logic [15:0] imm,
                        input logic [25:0] jx);
      id_stall = stall;
      br_valid = v;
      br_jump  = j;
      br_type  = t;
      br_zero  = z;
      br_pc    = pc;
      br_imm16 = imm;
      br_jidx  = jx;
      if (!rst && m_redirect(v, j, t, z)) model_restart(m_target(j, pc, imm, jx));
      else refill();
   endtask

   // No redirect, but junk on the other br_* lines to show br_valid gates them.
   task automatic quiet(input logic stall);
      drive(stall, 1'b0, 1'(1'($urandom)), 2'($urandom), 1'($urandom), $urandom, 16'($urandom), 26'($urandom));
   endtask

   task automatic rand_cycle();
      logic stall;
      stall = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 11) == 0)
         drive(stall, 1'b1, ($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom),
               32'h3000 + ($urandom_range(0, 255) << 2), 16'($urandom), 26'($urandom));
      else
         quiet(stall);
   endtask

   // Memory: answers each request after 0..lat_max cycles with mem_fn(addr).
   initial begin : responder
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         #1;
         if (stale_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            wait_cnt   = -1;
         end else if (rst || !imem_req) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wait_cnt   = -1;
         end else begin
            if (wait_cnt < 0) wait_cnt = lat_fixed ? lat_max : int'($urandom_range(0, lat_max));
            if (wait_cnt == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = mem_fn(imem_addr);
               wait_cnt   = -1;
            end else begin
               imem_ack   = 1'b0;
               imem_rdata = $urandom;
               wait_cnt--;
            end
         end
      end
   end

   // Monitor: samples just before each rising edge and scores accepted heads.
   initial begin : monitor
      logic        redir;
      logic [31:0] e;
      logic [31:0] ei;
      forever begin
         @(negedge clk);
         #4;
         if (p_rst) begin
            check1("rst_req_low", imem_req, 1'b0);
            check1("rst_valid_low", if_valid, 1'b0);
         end else begin
            if (p_redir) check1("flush_clears_valid", if_valid, 1'b0);
            if (p_req && !p_ack) begin
               check1("req_held", imem_req, 1'b1);
               check("addr_stable", imem_addr, p_addr);
            end
         end
         redir = m_redirect(br_valid, br_jump, br_type, br_zero);
         if (!rst && if_valid && !id_stall && !redir) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_empty actual=pop required=none");
            end else begin
               e  = exp_q.pop_front();
               ei = mem_fn(e);
               check("head_pc", if_pc, e);
               check("head_instr", if_instr, ei);
               check("head_opcode", {26'd0, if_opcode}, ei >> 26);
               check("head_funct", {26'd0, if_funct}, ei & 32'h3F);
               pops++;
            end
         end
         p_rst   = rst;
         p_redir = !rst && redir;
         p_req   = imem_req;
         p_ack   = imem_ack;
         p_addr  = imem_addr;
      end
   end

   initial begin : main
      logic [31:0] old_addr;
      bit          found;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 16'd0, 26'd0);
      model_restart(32'h0000_3000);
      repeat (3) begin tick(); quiet(1'b1); end
      stale_ack = 1'b1;          // ack lands in the first IDLE cycle after reset
      post();
      check1("rst_imem_req", imem_req, 1'b0);
      check("rst_imem_addr", imem_addr, 32'd0);
      check1("rst_if_valid", if_valid, 1'b0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_instr", if_instr, 32'd0);
      check("rst_opcode", {26'd0, if_opcode}, 32'd0);
      check("rst_funct", {26'd0, if_funct}, 32'd0);

      // Release reset with the decoder stalled and an immediate-ack memory.
      tick(); rst = 1'b0; stale_ack = 1'b0; quiet(1'b1);
      post();
      check1("first_req", imem_req, 1'b1);
      check("first_addr", imem_addr, 32'h0000_3000);
      check1("no_valid_before_ack", if_valid, 1'b0);
      tick(); quiet(1'b1);
      post();
      check1("valid_after_ack", if_valid, 1'b1);
      check("first_pc", if_pc, 32'h0000_3000);
      check("first_instr", if_instr, mem_fn(32'h0000_3000));
      repeat (5) begin tick(); quiet(1'b1); end
      post();
      check1("full_req_low", imem_req, 1'b0);
      check("full_head_held", if_pc, 32'h0000_3000);
      repeat (20) begin tick(); quiet(1'b0); end

      // beq taken backwards: 3010 + 4 - 16 = 3004.
      tick(); drive(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_3010, 16'hFFFC, 26'd0);
      post();
      check("beq_target_addr", imem_addr, 32'h0000_3004);
      check1("beq_req", imem_req, 1'b1);
      check1("beq_flush", if_valid, 1'b0);
      repeat (4) begin tick(); quiet(1'b0); end
      tick(); drive(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_3010, 16'hFFFC, 26'd0);
      tick(); drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_3010, 16'h0040, 26'd0);
      repeat (4) begin tick(); quiet(1'b0); end

      // Jump with a bne code alongside: jump wins, target 0x3040.
      tick(); drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 32'h0000_3000, 16'h0000, 26'h000_0C10);
      post();
      check("jump_target_addr", imem_addr, 32'h0000_3040);
      check1("jump_flush", if_valid, 1'b0);
      repeat (6) begin tick(); quiet(1'b0); end

      // Redirect while a request is outstanding (slow memory).
      lat_fixed = 1'b1;
      lat_max   = 3;
      repeat (3) begin tick(); quiet(1'b0); end
      found    = 1'b0;
      old_addr = 32'd0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (imem_req && !imem_ack) begin
            old_addr = imem_addr;
            drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_5000, 16'h0000, 26'h123_4567);
            found = 1'b1;
         end else begin
            quiet(1'b0);
         end
      end
      check1("drop_setup_found", found, 1'b1);
      post();
      check1("drop_req_held", imem_req, 1'b1);
      check("drop_addr_held", imem_addr, old_addr);
      check1("drop_flush", if_valid, 1'b0);
      repeat (12) begin tick(); quiet(1'b0); end

      // Randomized traffic.
      lat_fixed = 1'b0;
      lat_max   = 3;
      repeat (600) begin tick(); rand_cycle(); end

      // Reset in the middle of an outstanding request, then a stale ack.
      lat_fixed = 1'b1;
      found     = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (imem_req && !imem_ack) begin
            rst = 1'b1;
            model_restart(32'h0000_3000);
            quiet(1'b0);
            found = 1'b1;
         end else begin
            quiet(1'b0);
         end
      end
      check1("midrst_setup_found", found, 1'b1);
      post();
      check1("midrst_req_low", imem_req, 1'b0);
      check1("midrst_valid_low", if_valid, 1'b0);
      repeat (2) begin tick(); quiet(1'b0); end
      stale_ack = 1'b1;
      tick(); rst = 1'b0; stale_ack = 1'b0; quiet(1'b0);
      lat_fixed = 1'b0;
      repeat (60) begin tick(); rand_cycle(); end
      tick(); quiet(1'b0);

      checks++;
      if (pops < 100) begin
         failures++;
         $display("FAIL progress actual=%0d required>=100", pops);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
